// File: rtl/ber_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : ber_bcd_display
// Brief    : BER error count -> 8-digit packed BCD (serial double-dabble)
//            plus a multiplexed 8-digit 7-segment driver.
// Revision : 1.0 - initial release
// ============================================================================
module ber_bcd_display #(
    parameter int SCAN_DIV = 60000,
    parameter int BLANK_LZ = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_i,
    input  logic [31:0] error_count,
    output logic        busy_o,
    output logic [31:0] bcd_o,
    output logic        bcd_valid_o,
    output logic        ovf_o,
    output logic [7:0]  an_o,
    output logic [7:0]  seg_o
);

    localparam int                c_PRESC_W   = $clog2(SCAN_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_sh;
    logic [39:0]          r_scr;
    logic [4:0]           r_cnt;
    logic [31:0]          r_pend;
    logic                 r_pend_v;
    logic [31:0]          r_disp;
    logic [c_PRESC_W-1:0] r_presc;
    logic [2:0]           r_idx;
    logic [35:0]          w_adj;
    logic [3:0]           w_nib;
    logic                 w_blank;

    // Digit 9 never exceeds 4 for a 32-bit input, so only digits 0..8 need adjusting.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_add3
            assign w_adj[4*gi +: 4] = (r_scr[4*gi +: 4] >= 4'd5) ?
                                      r_scr[4*gi +: 4] + 4'd3 : r_scr[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_sh        <= 32'd0;
            r_scr       <= 40'd0;
            r_cnt       <= 5'd0;
            r_pend      <= 32'd0;
            r_pend_v    <= 1'b0;
            r_disp      <= 32'd0;
            busy_o      <= 1'b0;
            bcd_o       <= 32'd0;
            bcd_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            bcd_valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_sh    <= error_count;
                        r_scr   <= 40'd0;
                        r_cnt   <= 5'd0;
                        busy_o  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (valid_i) begin
                        r_pend   <= error_count;
                        r_pend_v <= 1'b1;
                    end
                    r_scr <= {r_scr[38:36], w_adj, r_sh[31]};
                    r_sh  <= {r_sh[30:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_valid_o <= 1'b1;
                    if (r_scr[39:32] != 8'd0) begin
                        bcd_o  <= 32'h9999_9999;
                        r_disp <= 32'h9999_9999;
                        ovf_o  <= 1'b1;
                    end else begin
                        bcd_o  <= r_scr[31:0];
                        r_disp <= r_scr[31:0];
                        ovf_o  <= 1'b0;
                    end
                    // A strobe arriving right now is the newest value and supersedes pending.
                    if (valid_i || r_pend_v) begin
                        r_sh     <= valid_i ? error_count : r_pend;
                        r_pend_v <= 1'b0;
                        r_scr    <= 40'd0;
                        r_cnt    <= 5'd0;
                        r_state  <= S_CONV;
                    end else begin
                        busy_o  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_nib   = r_disp[{r_idx, 2'b00} +: 4];
    assign w_blank = (BLANK_LZ != 0) && (r_idx != 3'd0) &&
                     ((r_disp >> {r_idx, 2'b00}) == 32'd0);
    assign an_o    = ~(8'd1 << r_idx);

    always_comb begin
        seg_o = 8'hFF;
        if (!w_blank) begin
            case (w_nib)
                4'd0:    seg_o = 8'hC0;
                4'd1:    seg_o = 8'hF9;
                4'd2:    seg_o = 8'hA4;
                4'd3:    seg_o = 8'hB0;
                4'd4:    seg_o = 8'h99;
                4'd5:    seg_o = 8'h92;
                4'd6:    seg_o = 8'h82;
                4'd7:    seg_o = 8'hF8;
                4'd8:    seg_o = 8'h80;
                4'd9:    seg_o = 8'h90;
                default: seg_o = 8'hFF;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ber_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_ber_bcd_display
// Brief    : Self-checking bench for ber_bcd_display against a decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ber_bcd_display;

    localparam int SCAN_DIV = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        valid_i;
    logic [31:0] error_count;
    logic        busy_o;
    logic [31:0] bcd_o;
    logic        bcd_valid_o;
    logic        ovf_o;
    logic [7:0]  an_o;
    logic [7:0]  seg_o;

    ber_bcd_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut (
        .CLK(CLK), .RST(RST), .valid_i(valid_i), .error_count(error_count),
        .busy_o(busy_o), .bcd_o(bcd_o), .bcd_valid_o(bcd_valid_o), .ovf_o(ovf_o),
        .an_o(an_o), .seg_o(seg_o)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    // Model state: conversion timing in edge numbers, displayed value as an integer.
    bit     m_busy, m_pv, m_pulse, m_ovf;
    longint m_cur, m_pd, m_disp;
    int     m_n, m_done, m_k;
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [31:0] to_bcd(longint v);
        logic [31:0] r;
        longint      t;
        r = 32'd0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_seg();
        int     idx;
        longint pw;
        idx = (m_k / SCAN_DIV) % 8;
        pw  = 1;
        for (int i = 0; i < idx; i++) pw = pw * 10;
        if (idx > 0 && m_disp < pw) return 8'hFF;
        return seg_tab[(m_disp / pw) % 10];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_pv = 0; m_pulse = 0; m_ovf = 0;
        m_cur = 0; m_pd = 0; m_disp = 0; m_n = 0; m_done = 0; m_k = 0;
    endtask

    task automatic model_start(input longint v);
        m_cur  = v;
        m_done = m_n + 33;
        m_busy = 1;
    endtask

    task automatic model_edge(input bit v, input logic [31:0] d);
        m_n++;
        m_k++;
        m_pulse = 0;
        if (!m_busy) begin
            if (v) model_start({32'd0, d});
        end else if (m_n == m_done) begin
            m_pulse = 1;
            m_ovf   = (m_cur > 99_999_999);
            m_disp  = m_ovf ? 99_999_999 : m_cur;
            if (v) begin
                model_start({32'd0, d});
                m_pv = 0;
            end else if (m_pv) begin
                model_start(m_pd);
                m_pv = 0;
            end else begin
                m_busy = 0;
            end
        end else if (v) begin
            m_pv = 1;
            m_pd = {32'd0, d};
        end
    endtask

    task automatic compare_all();
        chk("busy_o", {31'd0, busy_o}, {31'd0, m_busy});
        chk("bcd_valid_o", {31'd0, bcd_valid_o}, {31'd0, m_pulse});
        chk("bcd_o", bcd_o, to_bcd(m_disp));
        chk("ovf_o", {31'd0, ovf_o}, {31'd0, m_ovf});
        chk("an_o", {24'd0, an_o}, {24'd0, ~(8'd1 << ((m_k / SCAN_DIV) % 8))});
        chk("seg_o", {24'd0, seg_o}, {24'd0, exp_seg()});
    endtask

    // Inputs change at the falling edge; outputs are compared at the next falling edge.
    task automatic tick(input bit v, input logic [31:0] d);
        valid_i     = v;
        error_count = d;
        @(posedge CLK);
        model_edge(v, d);
        @(negedge CLK);
        compare_all();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("reset_an", {24'd0, an_o}, 32'h0000_00FE);
        chk("reset_seg", {24'd0, seg_o}, 32'h0000_00C0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] d, output int lat, output int bcnt,
                           output logic [31:0] val, output logic ovf);
        tick(1'b1, d);
        bcnt = busy_o ? 1 : 0;
        lat  = -1;
        val  = 32'hDEAD_BEEF;
        ovf  = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 32'd0);
            if (busy_o) bcnt++;
            if (bcd_valid_o && lat < 0) begin
                lat = i;
                val = bcd_o;
                ovf = ovf_o;
            end
        end
    endtask

    initial begin
        int          lat, bcnt, npulse;
        logic [31:0] val;
        logic        ovf;
        bit          seen7f;
        int          pt [2];
        logic [31:0] pv [2];

        RST = 1'b1;
        valid_i = 1'b0;
        error_count = 32'd0;
        do_reset();

        // Zero converts to a single lit "0".
        run_one(32'd0, lat, bcnt, val, ovf);
        chk("t1_latency", lat, 33);
        chk("t1_bcd", val, 32'h0);
        chk("t1_ovf", {31'd0, ovf}, 32'd0);

        // Mid-range count and the full scan sweep.
        run_one(32'd12_345_678, lat, bcnt, val, ovf);
        chk("t2_latency", lat, 33);
        chk("t2_bcd", val, 32'h1234_5678);
        seen7f = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 32'd0);
            if (an_o == 8'h7F && !seen7f) begin
                seen7f = 1;
                chk("t2_seg_digit7", {24'd0, seg_o}, 32'h0000_00F9);
            end
        end
        chk("t2_seen_digit7", {31'd0, seen7f}, 32'd1);

        // Saturation, then recovery.
        run_one(32'd100_000_000, lat, bcnt, val, ovf);
        chk("t3_bcd_sat", val, 32'h9999_9999);
        chk("t3_ovf", {31'd0, ovf}, 32'd1);
        run_one(32'd5, lat, bcnt, val, ovf);
        chk("t3_bcd_5", val, 32'h0000_0005);
        chk("t3_ovf_clear", {31'd0, ovf}, 32'd0);

        // Strobes while busy: latest pending wins.
        npulse = 0;
        for (int i = 0; i <= 80; i++) begin
            tick(i == 0 || i == 5 || i == 10,
                 (i == 0) ? 32'd42 : (i == 5) ? 32'd7 : 32'd9);
            if (bcd_valid_o) begin
                if (npulse < 2) begin
                    pt[npulse] = i;
                    pv[npulse] = bcd_o;
                end
                npulse++;
            end
        end
        chk("t4_npulse", npulse, 2);
        if (npulse >= 2) begin
            chk("t4_p0_time", pt[0], 33);
            chk("t4_p0_val", pv[0], 32'h42);
            chk("t4_p1_time", pt[1], 66);
            chk("t4_p1_val", pv[1], 32'h9);
        end

        // Reset mid-conversion aborts with no pulse.
        tick(1'b1, 32'd99);
        for (int i = 1; i <= 14; i++) tick(1'b0, 32'd0);
        do_reset();
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 32'd0);
            if (bcd_valid_o) npulse++;
        end
        chk("t5_no_pulse", npulse, 0);
        run_one(32'd123, lat, bcnt, val, ovf);
        chk("t5_after_reset", val, 32'h123);
        chk("t5_latency", lat, 33);

        // Full-scale input.
        run_one(32'hFFFF_FFFF, lat, bcnt, val, ovf);
        chk("t6_bcd_sat", val, 32'h9999_9999);
        chk("t6_ovf", {31'd0, ovf}, 32'd1);
        chk("t6_busy_cycles", bcnt, 33);

        // Randomized traffic including back-to-back and overlapping strobes.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 99_999_999);
            if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 999);
            tick($urandom_range(0, 15) == 0, d);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
